// File: rtl/bcd_fmt_pkg.sv
// Shared constants, FSM states and digit-word packing for the BCD digit formatter.
package bcd_fmt_pkg;

   localparam int          DIGITS  = 8;
   localparam logic [31:0] MAX_DEC = 32'd99_999_999;

   localparam int EN_BIT  = 5;
   localparam int HEX_MSB = 4;
   localparam int HEX_LSB = 1;
   localparam int DP_BIT  = 0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      FORMAT = 2'd2
   } state_t;

   function automatic logic [5:0] pack_digit(input logic en, input logic [3:0] hex, input logic dp);
      logic [5:0] w;
      w                  = '0;
      w[EN_BIT]          = en;
      w[HEX_MSB:HEX_LSB] = hex;
      w[DP_BIT]          = dp;
      return w;
   endfunction

endpackage

// File: rtl/dabble_step.sv
// One double-dabble correction: every BCD nibble of 5 or more gets +3 ahead of the shift.
module dabble_step
   import bcd_fmt_pkg::*;
(
   input  logic [31:0] bcd_in,
   output logic [31:0] bcd_out
);

   always_comb begin
      bcd_out = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_in[4*i +: 4] >= 4'd5)
            bcd_out[4*i +: 4] = bcd_in[4*i +: 4] + 4'd3;
         else
            bcd_out[4*i +: 4] = bcd_in[4*i +: 4];
      end
   end

endmodule

// File: rtl/bcd_digit_formatter.sv
// Iterative binary-to-BCD converter with leading-zero blanking and decimal-point mask,
// producing eight {en, hex, dp} words for the seven-segment driver.
module bcd_digit_formatter
   import bcd_fmt_pkg::*;
#(
   parameter int BIN_W = 27
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [BIN_W-1:0] bin,
   input  logic [7:0]       dp_mask,
   input  logic             blank_lz,
   output logic             busy,
   output logic             done,
   output logic             ovf,
   output logic [5:0]       d7,
   output logic [5:0]       d6,
   output logic [5:0]       d5,
   output logic [5:0]       d4,
   output logic [5:0]       d3,
   output logic [5:0]       d2,
   output logic [5:0]       d1,
   output logic [5:0]       d0
);

   localparam int CNT_W = $clog2(BIN_W + 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [BIN_W-1:0] bin_sr;
   logic [31:0]      bcd;
   logic [31:0]      bcd_adj;
   logic [31:0]      bin_ext;
   logic [7:0]       dp_cap;
   logic             blz_cap;
   logic             ovf_cap;
   logic             accept;
   logic             last_shift;
   logic [7:0]       en;
   logic             seen;
   logic [5:0]       digits [DIGITS];

   dabble_step u_step (
      .bcd_in  (bcd),
      .bcd_out (bcd_adj)
   );

   assign bin_ext    = 32'(bin);
   assign accept     = (state == IDLE) && start;
   assign last_shift = (cnt == CNT_W'(BIN_W - 1));
   assign busy       = (state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SHIFT;
         SHIFT:   if (last_shift) state_nxt = FORMAT;
         FORMAT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Conversion datapath: capture, then one add-3/shift per cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (accept) begin
         bin_sr  <= (bin_ext > MAX_DEC) ? MAX_DEC[BIN_W-1:0] : bin;
         ovf_cap <= (bin_ext > MAX_DEC);
         dp_cap  <= dp_mask;
         blz_cap <= blank_lz;
         bcd     <= '0;
         cnt     <= '0;
      end else if (state == SHIFT) begin
         bcd    <= {bcd_adj[30:0], bin_sr[BIN_W-1]};
         bin_sr <= bin_sr << 1;
         cnt    <= cnt + 1'b1;
      end
   end

   // A digit stays lit if anything at or above it is non-zero or carries a point.
   always_comb begin
      en   = '0;
      seen = 1'b0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         seen  = seen | (bcd[4*i +: 4] != 4'd0) | dp_cap[i];
         en[i] = !blz_cap || (i == 0) || seen;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         done <= 1'b0;
         ovf  <= 1'b0;
         for (int i = 0; i < DIGITS; i++) digits[i] <= '0;
      end else begin
         done <= (state == FORMAT);
         if (state == FORMAT) begin
            ovf <= ovf_cap;
            for (int i = 0; i < DIGITS; i++)
               digits[i] <= pack_digit(en[i], bcd[4*i +: 4], dp_cap[i]);
         end
      end
   end

   assign d0 = digits[0];
   assign d1 = digits[1];
   assign d2 = digits[2];
   assign d3 = digits[3];
   assign d4 = digits[4];
   assign d5 = digits[5];
   assign d6 = digits[6];
   assign d7 = digits[7];

endmodule
